uart_rx_frame: RTL and testbench

//  Serial UART receiver feeding the command engine's read path: deserialises rx into

---
 rtl/uart_rx_frame_pkg.sv | 28 ++
 rtl/uart_rx_frame_if.sv | 36 +++
 rtl/uart_rx_frame_sampler.sv | 54 +++++
 rtl/uart_rx_frame.sv | 133 +++++++++++++
 tb/tb_uart_rx_frame.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_pkg.sv
//============================================================================
// Module   : uart_rx_frame_pkg
// Desc     : Shared UART receiver types: FSM states, default bit period and
//            the parity helper shared with the transmit side.
// Revision : 1.0
//============================================================================
`default_nettype none

package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam int C_BR_DEFAULT = 434;

    // Zero-extending the data word does not change its parity.
    function automatic logic par(input logic [63:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
//============================================================================
// Module   : uart_rx_frame_if
// Desc     : Valid/ready output register bundle of the UART receiver.
// Revision : 1.0
//============================================================================
`default_nettype none

interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_vld;
    logic                  rx_rdy;
    logic                  parity_err;
    logic                  frame_err;

    modport master (
        output rx_data,
        output rx_vld,
        output parity_err,
        output frame_err,
        input  rx_rdy
    );

    modport slave (
        input  rx_data,
        input  rx_vld,
        input  parity_err,
        input  frame_err,
        output rx_rdy
    );

endinterface

`default_nettype wire

// File: rtl/uart_rx_frame_sampler.sv
//============================================================================
// Module   : uart_rx_frame_sampler
// Desc     : rx synchroniser, falling-edge detect and mid-bit 3-sample vote.
// Revision : 1.0
//============================================================================
`default_nettype none

module uart_rx_frame_sampler #(
    parameter int BR = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic [$clog2(BR)-1:0] br_cnt,
    output logic                  fall,
    output logic                  bit_val,
    output logic                  bit_dec
);

    localparam int            CW    = $clog2(BR);
    localparam logic [CW-1:0] C_S0  = CW'(BR / 2 - 1);
    localparam logic [CW-1:0] C_S1  = CW'(BR / 2);
    localparam logic [CW-1:0] C_DEC = CW'(BR / 2 + 1);

    logic r_sync1;
    logic r_rx_s;
    logic r_rx_s_d;
    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
        end else begin
            r_sync1  <= rx;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
            if (br_cnt == C_S0) r_s0 <= r_rx_s;
            if (br_cnt == C_S1) r_s1 <= r_rx_s;
        end
    end

    // Third sample is the live synchronised value on the decision cycle.
    assign fall    = ~r_rx_s & r_rx_s_d;
    assign bit_dec = (br_cnt == C_DEC);
    assign bit_val = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
//============================================================================
// Module   : uart_rx_frame
// Desc     : UART receiver: frame FSM, bit counters and valid/ready output
//            register with parity, framing and overrun reporting.
// Revision : 1.0
//============================================================================
`default_nettype none

module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int BR         = C_BR_DEFAULT,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    uart_rx_frame_if.master  rx_if,
    output logic             overrun,
    output logic             busy
);

    localparam int            CW         = $clog2(BR);
    localparam int            BW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST     = CW'(BR - 1);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    logic [CW-1:0]         r_br_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_par_bit;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_vld;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic w_fall;
    logic w_bit_val;
    logic w_bit_dec;
    logic w_wrap;

    uart_rx_frame_sampler #(.BR(BR)) u_sampler (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .br_cnt  (r_br_cnt),
        .fall    (w_fall),
        .bit_val (w_bit_val),
        .bit_dec (w_bit_dec)
    );

    assign w_wrap = (r_br_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_br_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_par_bit    <= 1'b0;
            r_rx_data    <= '0;
            r_rx_vld     <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_rx_vld && rx_if.rx_rdy) r_rx_vld <= 1'b0;

            if (r_state == RX_IDLE) r_br_cnt <= '0;
            else                    r_br_cnt <= w_wrap ? '0 : r_br_cnt + CW'(1);

            case (r_state)
                RX_IDLE: begin
                    if (w_fall) r_state <= RX_START;
                end
                RX_START: begin
                    if (w_bit_dec && w_bit_val) begin
                        r_state  <= RX_IDLE;
                        r_br_cnt <= '0;
                    end else if (w_wrap) begin
                        r_state   <= RX_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    if (w_bit_dec) r_shreg[r_bit_cnt] <= w_bit_val;
                    if (w_wrap) begin
                        if (r_bit_cnt == C_BIT_LAST)
                            r_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
                RX_PARITY: begin
                    if (w_bit_dec) r_par_bit <= w_bit_val;
                    if (w_wrap)    r_state   <= RX_STOP;
                end
                RX_STOP: begin
                    // Leave early so a start edge half a bit later is still seen.
                    if (w_bit_dec) begin
                        r_state  <= RX_IDLE;
                        r_br_cnt <= '0;
                        if (r_rx_vld && !rx_if.rx_rdy) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_rx_data    <= r_shreg;
                            r_rx_vld     <= 1'b1;
                            r_frame_err  <= ~w_bit_val;
                            r_parity_err <= (PARITY_EN != 0) &&
                                            (r_par_bit != par(64'(r_shreg), PARITY_ODD != 0));
                        end
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_if.rx_data    = r_rx_data;
    assign rx_if.rx_vld     = r_rx_vld;
    assign rx_if.parity_err = r_parity_err;
    assign rx_if.frame_err  = r_frame_err;
    assign overrun          = r_overrun;
    assign busy             = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
//============================================================================
// Module   : tb_uart_rx_frame
// Desc     : Self-checking bench for uart_rx_frame with a frame-level model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int BR = 16;
    localparam int DW = 8;
    // Start edge to rx_vld: 10 bit periods + half bit + 2, plus 3 synchroniser clocks.
    localparam int C_LAT = (1 + DW + 1) * BR + BR / 2 + 2 + 3;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic overrun;
    logic busy;

    uart_rx_frame_if #(.DATA_WIDTH(DW)) rif ();

    uart_rx_frame #(
        .BR         (BR),
        .DATA_WIDTH (DW),
        .PARITY_EN  (1),
        .PARITY_ODD (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_if   (rif),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            vld_cyc = -1;
    int            ovr_seen = 0;
    int            ovr_exp = 0;
    exp_t          q[$];
    exp_t          e;
    logic [DW-1:0] last_d;
    logic          last_pe;
    logic          last_fe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Every accepted word must match the oldest frame the model expects.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (overrun === 1'b1) ovr_seen++;
            if (rif.rx_vld === 1'b1 && rif.rx_rdy === 1'b1) begin
                vld_cyc = cyc;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_word: got rx_data=%h, expected no word", rif.rx_data);
                end else begin
                    e = q.pop_front();
                    chk("rx_data", 32'(rif.rx_data), 32'(e.d));
                    chk("parity_err", 32'(rif.parity_err), 32'(e.pe));
                    chk("frame_err", 32'(rif.frame_err), 32'(e.fe));
                    last_d  = rif.rx_data;
                    last_pe = rif.parity_err;
                    last_fe = rif.frame_err;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input bit fl);
        for (int c = 0; c < BR; c++) begin
            rx = (fl && c == BR / 2 + 1) ? ~b : b;
            tick(1);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // flip_idx selects one data bit that gets a single-clock mid-bit glitch (-1: none).
    task automatic send(input logic [DW-1:0] d, input bit par_good, input bit stop,
                        input int flip_idx, input bit expect_it);
        logic pb;
        exp_t x;
        pb = (($countones(d) % 2) == 0);
        if (!par_good) pb = ~pb;
        if (expect_it) begin
            x.d  = d;
            x.pe = ((($countones(d) + int'(pb)) % 2) == 0);
            x.fe = ~stop;
            q.push_back(x);
        end
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i], flip_idx == i);
        drive_bit(pb, 1'b0);
        drive_bit(stop, 1'b0);
        rx = 1'b1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 8 * BR) begin
            tick(1);
            k++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int lat;
        logic [DW-1:0] d;
        bit pg;
        bit sb;
        int fi;

        rx = 1'b1;
        rif.rx_rdy = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("reset_rx_vld", 32'(rif.rx_vld), 32'd0);
        chk("reset_rx_data", 32'(rif.rx_data), 32'd0);
        chk("reset_parity_err", 32'(rif.parity_err), 32'd0);
        chk("reset_frame_err", 32'(rif.frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Clean frame and its latency.
        st = cyc;
        send(8'hA5, 1'b1, 1'b1, -1, 1'b1);
        wait_drain();
        lat = vld_cyc - st;
        n_cmp++;
        if (lat < C_LAT - 2 || lat > C_LAT + 2) begin
            n_bad++;
            $display("FAIL t1_latency: got %0d, expected %0d +/- 2", lat, C_LAT);
        end
        chk("t1_data", 32'(last_d), 32'h A5);
        chk("t1_perr", 32'(last_pe), 32'd0);
        chk("t1_ferr", 32'(last_fe), 32'd0);
        idle(BR);

        // Wrong parity bit.
        send(8'h3C, 1'b0, 1'b1, -1, 1'b1);
        wait_drain();
        chk("t2_data", 32'(last_d), 32'h3C);
        chk("t2_perr", 32'(last_pe), 32'd1);
        chk("t2_ferr", 32'(last_fe), 32'd0);
        idle(BR);

        // Stop bit low, then a normal frame.
        send(8'h81, 1'b1, 1'b0, -1, 1'b1);
        wait_drain();
        chk("t3_ferr", 32'(last_fe), 32'd1);
        idle(BR);
        send(8'h42, 1'b1, 1'b1, -1, 1'b1);
        wait_drain();
        chk("t3b_data", 32'(last_d), 32'h42);
        chk("t3b_ferr", 32'(last_fe), 32'd0);
        idle(BR);

        // Short low glitch on idle line.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(1);
        chk("t4_busy_high", 32'(busy), 32'd1);
        tick(BR / 2 + 1);
        chk("t4_busy_low", 32'(busy), 32'd0);
        idle(2 * BR);

        // Back-to-back frames with the consumer stalled.
        rif.rx_rdy = 1'b0;
        send(8'h11, 1'b1, 1'b1, -1, 1'b1);
        send(8'h22, 1'b1, 1'b1, -1, 1'b0);
        ovr_exp++;
        idle(BR);
        chk("t5_vld_held", 32'(rif.rx_vld), 32'd1);
        chk("t5_data_held", 32'(rif.rx_data), 32'h11);
        chk("t5_overrun_count", 32'(ovr_seen), 32'd1);
        rif.rx_rdy = 1'b1;
        tick(1);
        chk("t5_vld_drop", 32'(rif.rx_vld), 32'd0);
        chk("t5_accepted", 32'(last_d), 32'h11);
        idle(BR);

        // Reset in the middle of data bit 4 of 0xFF.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        tick(BR / 2);
        rst_n = 1'b0;
        tick(2);
        chk("t6_busy_in_reset", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(2 * BR);
        chk("t6_no_word", 32'(rif.rx_vld), 32'd0);
        send(8'h5A, 1'b1, 1'b1, 3, 1'b1);
        wait_drain();
        chk("t6_data_voted", 32'(last_d), 32'h5A);
        idle(BR);

        // Randomised traffic.
        for (int n = 0; n < 16; n++) begin
            d  = DW'($urandom);
            pg = ($urandom_range(0, 3) != 0);
            sb = ($urandom_range(0, 4) != 0);
            fi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            send(d, pg, sb, fi, 1'b1);
            idle(int'($urandom_range(0, BR)) + (sb ? 0 : 4));
        end
        wait_drain();
        chk("overrun_total", 32'(ovr_seen), 32'(ovr_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
